// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single data-cache port between MEM-stage
// loads and store-buffer drains, with anti-starvation and a fence/context
// switch flush that drains the whole store buffer.
module dcache_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_req,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_done,
    input  logic                     sb_valid,
    input  logic [ADDR_W+DATA_W-1:0] sb_entry,
    input  logic                     sb_full,
    output logic                     sb_pop,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     stall,
    output logic                     dc_req,
    output logic                     dc_we,
    output logic [ADDR_W-1:0]        dc_addr,
    output logic [DATA_W-1:0]        dc_wdata,
    input  logic                     dc_ack,
    input  logic [DATA_W-1:0]        dc_rdata
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_FLUSH
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    starve_q,     starve_d;
    logic                dc_req_q,     dc_req_d;
    logic                dc_we_q,      dc_we_d;
    logic [ADDR_W-1:0]   dc_addr_q,    dc_addr_d;
    logic [DATA_W-1:0]   dc_wdata_q,   dc_wdata_d;
    logic [DATA_W-1:0]   ld_data_q,    ld_data_d;
    logic                ld_done_q,    ld_done_d;
    logic                sb_pop_q,     sb_pop_d;
    logic                flush_done_q, flush_done_d;

    logic                take_load;
    logic                take_store;
    logic                hold_idle;

    // A completion pulse means the request inputs (ld_req, flush) still show
    // the request just served, and after sb_pop the buffer has not shifted
    // yet, so IDLE waits one cycle before arbitrating again.
    assign hold_idle = ld_done_q | sb_pop_q | flush_done_q;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        dc_req_d     = dc_req_q;
        dc_we_d      = dc_we_q;
        dc_addr_d    = dc_addr_q;
        dc_wdata_d   = dc_wdata_q;
        ld_data_d    = ld_data_q;
        ld_done_d    = 1'b0;
        sb_pop_d     = 1'b0;
        flush_done_d = 1'b0;
        take_load    = 1'b0;
        take_store   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!hold_idle) begin
                    if (flush) begin
                        state_d = S_FLUSH;
                    end else if (sb_valid && (sb_full || (starve_q == STARVE_LIM))) begin
                        take_store = 1'b1;
                        state_d    = S_STORE;
                    end else if (ld_req) begin
                        take_load = 1'b1;
                        state_d   = S_LOAD;
                        if (sb_valid && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end else if (sb_valid) begin
                        take_store = 1'b1;
                        state_d    = S_STORE;
                    end
                end
            end

            S_LOAD: begin
                if (dc_ack) begin
                    dc_req_d  = 1'b0;
                    ld_data_d = dc_rdata;
                    ld_done_d = 1'b1;
                    state_d   = flush ? S_FLUSH : S_IDLE;
                end
            end

            S_STORE: begin
                if (dc_ack) begin
                    dc_req_d = 1'b0;
                    sb_pop_d = 1'b1;
                    starve_d = '0;
                    state_d  = flush ? S_FLUSH : S_IDLE;
                end
            end

            S_FLUSH: begin
                if (dc_req_q) begin
                    if (dc_ack) begin
                        dc_req_d = 1'b0;
                        sb_pop_d = 1'b1;
                        starve_d = '0;
                    end
                end else if (!sb_pop_q) begin
                    // sb_valid is only trusted once the shift after a pop is done
                    if (sb_valid) begin
                        take_store = 1'b1;
                    end else begin
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_load) begin
            dc_req_d  = 1'b1;
            dc_we_d   = 1'b0;
            dc_addr_d = ld_addr;
        end

        if (take_store) begin
            dc_req_d   = 1'b1;
            dc_we_d    = 1'b1;
            dc_addr_d  = sb_entry[ADDR_W+DATA_W-1:DATA_W];
            dc_wdata_d = sb_entry[DATA_W-1:0];
        end
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            dc_req_q     <= 1'b0;
            dc_we_q      <= 1'b0;
            dc_addr_q    <= '0;
            dc_wdata_q   <= '0;
            ld_data_q    <= '0;
            ld_done_q    <= 1'b0;
            sb_pop_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            dc_req_q     <= dc_req_d;
            dc_we_q      <= dc_we_d;
            dc_addr_q    <= dc_addr_d;
            dc_wdata_q   <= dc_wdata_d;
            ld_data_q    <= ld_data_d;
            ld_done_q    <= ld_done_d;
            sb_pop_q     <= sb_pop_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign dc_req     = dc_req_q;
    assign dc_we      = dc_we_q;
    assign dc_addr    = dc_addr_q;
    assign dc_wdata   = dc_wdata_q;
    assign ld_data    = ld_data_q;
    assign ld_done    = ld_done_q;
    assign sb_pop     = sb_pop_q;
    assign flush_done = flush_done_q;

    // stall must rise in the same cycle as the request, so it combines the
    // live request levels with the registered completion pulses.
    assign stall = (ld_req & ~ld_done_q) | (flush & ~flush_done_q);

endmodule
